// File: rtl/ahb_bus_pkg.sv
// Shared encodings for the 3-slave system bus: transfer types, data-phase
// select codes, response codes, the default address map and the state
// encoding of the default slave. No ports.
package ahb_bus_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_S1   = 2'b01,
        SEL_S2   = 2'b10,
        SEL_S3   = 2'b11
    } sel_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Default HADDR[31:28] regions of the three slaves
    localparam logic [3:0] S1_REGION_DEF = 4'h0;
    localparam logic [3:0] S2_REGION_DEF = 4'h1;
    localparam logic [3:0] S3_REGION_DEF = 4'h2;

    typedef enum logic [1:0] {
        DS_OKAY = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers a transfer to an unmapped address with the AHB
// two-cycle ERROR response (HREADY low + ERROR, then HREADY high + ERROR).
// Ports:
//   CLK, RST    clock; asynchronous active-high reset
//   ds_err_req  an unmapped NONSEQ/SEQ transfer is being accepted this edge
//   ds_hready   HREADY contribution while no real slave owns the data phase
//   ds_hresp    HRESP contribution while no real slave owns the data phase
module ahb_default_slave
    import ahb_bus_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic ds_err_req,
    output logic ds_hready,
    output logic ds_hresp
);

    ds_state_t state, state_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= DS_OKAY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ds_hready  = 1'b1;
        ds_hresp   = HRESP_OKAY;
        case (state)
            DS_OKAY: begin
                if (ds_err_req) begin
                    state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                // Stall cycle of the error; always completes, whatever the master does.
                ds_hready  = 1'b0;
                ds_hresp   = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                // HREADY is high here, so a new address phase is sampled now.
                ds_hresp   = HRESP_ERROR;
                state_next = ds_err_req ? DS_ERR1 : DS_OKAY;
            end
            default: begin
                state_next = DS_OKAY;
            end
        endcase
    end

endmodule

// File: rtl/ahb_addr_decoder.sv
// Address decoder and data-phase response mux for the 3-slave system bus.
// Ports:
//   CLK, RST              clock; asynchronous active-high reset
//   HADDR, HTRANS         master address phase
//   HREADY_x, HRESP_x     per-slave ready/response (x = 1..3)
//   HSEL_x                combinational address-phase slave selects
//   SEL                   registered data-phase select for the read-data mux
//   HREADY, HRESP         bus ready/response returned to master and slaves
module ahb_addr_decoder
    import ahb_bus_pkg::*;
#(
    parameter logic [3:0] S1_REGION = S1_REGION_DEF,
    parameter logic [3:0] S2_REGION = S2_REGION_DEF,
    parameter logic [3:0] S3_REGION = S3_REGION_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY_1,
    input  logic        HREADY_2,
    input  logic        HREADY_3,
    input  logic        HRESP_1,
    input  logic        HRESP_2,
    input  logic        HRESP_3,
    output logic        HSEL_1,
    output logic        HSEL_2,
    output logic        HSEL_3,
    output logic [1:0]  SEL,
    output logic        HREADY,
    output logic        HRESP
);

    logic       active;
    logic       hit_1, hit_2, hit_3;
    logic       ds_err_req;
    logic       ds_hready, ds_hresp;
    sel_t       sel_d, sel_q;
    logic       unused_addr;

    // NONSEQ and SEQ both have HTRANS[1] set; IDLE/BUSY never select a slave.
    assign active = HTRANS[1];
    assign hit_1  = (HADDR[31:28] == S1_REGION);
    assign hit_2  = (HADDR[31:28] == S2_REGION);
    assign hit_3  = (HADDR[31:28] == S3_REGION);

    assign HSEL_1 = active & hit_1;
    assign HSEL_2 = active & hit_2;
    assign HSEL_3 = active & hit_3;

    assign unused_addr = &{1'b0, HADDR[27:0], HTRANS[0]};

    always_comb begin
        sel_d = SEL_NONE;
        if (HSEL_1) begin
            sel_d = SEL_S1;
        end else if (HSEL_2) begin
            sel_d = SEL_S2;
        end else if (HSEL_3) begin
            sel_d = SEL_S3;
        end
    end

    // Address phase is only accepted on an edge where HREADY is high, so a
    // stall freezes the data-phase owner regardless of HADDR/HTRANS.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel_q <= SEL_NONE;
        end else if (HREADY) begin
            sel_q <= sel_d;
        end
    end

    assign SEL = sel_q;

    assign ds_err_req = HREADY & active & ~(hit_1 | hit_2 | hit_3);

    ahb_default_slave u_default_slave (
        .CLK        (CLK),
        .RST        (RST),
        .ds_err_req (ds_err_req),
        .ds_hready  (ds_hready),
        .ds_hresp   (ds_hresp)
    );

    // HREADY never depends on HADDR/HTRANS, so ds_err_req forms no loop.
    always_comb begin
        HREADY = ds_hready;
        HRESP  = ds_hresp;
        case (sel_q)
            SEL_S1: begin
                HREADY = HREADY_1;
                HRESP  = HRESP_1;
            end
            SEL_S2: begin
                HREADY = HREADY_2;
                HRESP  = HRESP_2;
            end
            SEL_S3: begin
                HREADY = HREADY_3;
                HRESP  = HRESP_3;
            end
            default: begin
                HREADY = ds_hready;
                HRESP  = ds_hresp;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// Testbench for ahb_addr_decoder: directed bus scenarios followed by random
// traffic, compared against a transaction-level reference model.
module tb_ahb_addr_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  rdy_v = 3'b111;
    logic [2:0]  rsp_v = 3'b000;
    logic        HSEL_1, HSEL_2, HSEL_3;
    logic [1:0]  SEL;
    logic        HREADY, HRESP;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: which slave (0 = none) owns the data phase, and
    // how many cycles of an ERROR response remain to be shown (2, 1 or 0).
    int m_sel = 0;
    int m_err = 0;

    ahb_addr_decoder dut (
        .CLK      (CLK),
        .RST      (RST),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HREADY_1 (rdy_v[0]),
        .HREADY_2 (rdy_v[1]),
        .HREADY_3 (rdy_v[2]),
        .HRESP_1  (rsp_v[0]),
        .HRESP_2  (rsp_v[1]),
        .HRESP_3  (rsp_v[2]),
        .HSEL_1   (HSEL_1),
        .HSEL_2   (HSEL_2),
        .HSEL_3   (HSEL_3),
        .SEL      (SEL),
        .HREADY   (HREADY),
        .HRESP    (HRESP)
    );

    always #5 CLK = ~CLK;

    // Slave number 1..3 for regions 0x0..0x2, 0 for everything else.
    function automatic int region_of(input logic [31:0] a);
        int r;
        r = int'(a[31:28]);
        return (r < 3) ? r + 1 : 0;
    endfunction

    function automatic logic exp_ready();
        if (m_sel != 0) return rdy_v[m_sel-1];
        return (m_err != 2);
    endfunction

    function automatic logic exp_resp();
        if (m_sel != 0) return rsp_v[m_sel-1];
        return (m_err != 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int tgt;
        tgt = htrans[1] ? region_of(haddr) : 0;
        chk({tag, ".hsel1"}, {31'b0, HSEL_1}, {31'b0, tgt == 1});
        chk({tag, ".hsel2"}, {31'b0, HSEL_2}, {31'b0, tgt == 2});
        chk({tag, ".hsel3"}, {31'b0, HSEL_3}, {31'b0, tgt == 3});
        chk({tag, ".sel"},   {30'b0, SEL},    32'(m_sel));
        chk({tag, ".hready"}, {31'b0, HREADY}, {31'b0, exp_ready()});
        chk({tag, ".hresp"},  {31'b0, HRESP},  {31'b0, exp_resp()});
    endtask

    task automatic model_clock();
        int tgt;
        if (RST) begin
            m_sel = 0;
            m_err = 0;
        end else if (exp_ready()) begin
            tgt   = htrans[1] ? region_of(haddr) : 0;
            m_sel = tgt;
            m_err = (htrans[1] && tgt == 0) ? 2 : 0;
        end else if (m_err == 2) begin
            m_err = 1;
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t,
                         input logic [2:0] r, input logic [2:0] p);
        haddr  = a;
        htrans = t;
        rdy_v  = r;
        rsp_v  = p;
        #2;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    initial begin
        logic [3:0]  rg;
        logic [31:0] ra;

        // Reset with an active transfer to slave 1 on the bus
        #1;
        drive(32'h0000_0000, 2'b10, 3'b111, 3'b000);
        check_all("reset");
        chk("reset.hsel1_direct", {31'b0, HSEL_1}, 32'd1);
        chk("reset.hready_direct", {31'b0, HREADY}, 32'd1);
        tick();
        RST = 1'b0;

        // IDLE to a mapped address selects nothing
        drive(32'h1000_0000, 2'b00, 3'b111, 3'b000);
        check_all("idle_mapped");
        chk("idle_mapped.hsel2_direct", {31'b0, HSEL_2}, 32'd0);
        tick();

        // Slave 2 read with two wait states; address changes during the stall ignored
        drive(32'h1000_0010, 2'b10, 3'b111, 3'b000);
        check_all("s2_addr");
        tick();
        drive(32'h3000_0000, 2'b10, 3'b101, 3'b000);
        check_all("s2_wait1");
        chk("s2_wait1.sel_direct", {30'b0, SEL}, 32'h2);
        chk("s2_wait1.hready_direct", {31'b0, HREADY}, 32'd0);
        tick();
        drive(32'h0000_0000, 2'b11, 3'b101, 3'b000);
        check_all("s2_wait2");
        chk("s2_wait2.sel_direct", {30'b0, SEL}, 32'h2);
        tick();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        check_all("s2_done");
        chk("s2_done.sel_direct", {30'b0, SEL}, 32'h2);
        tick();

        // Pipelined slave 1 then slave 3
        drive(32'h0000_0004, 2'b10, 3'b111, 3'b000);
        check_all("pipe_s1");
        tick();
        drive(32'h2000_0008, 2'b11, 3'b111, 3'b000);
        check_all("pipe_s3");
        chk("pipe_s3.sel_direct", {30'b0, SEL}, 32'h1);
        tick();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        check_all("pipe_end");
        chk("pipe_end.sel_direct", {30'b0, SEL}, 32'h3);
        tick();

        // Single unmapped transfer; master goes IDLE during the first error cycle
        drive(32'h3000_0000, 2'b10, 3'b111, 3'b000);
        check_all("unm_addr");
        tick();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        check_all("unm_err1");
        chk("unm_err1.resp_direct", {30'b0, HREADY, HRESP}, 32'b01);
        tick();
        check_all("unm_err2");
        chk("unm_err2.resp_direct", {30'b0, HREADY, HRESP}, 32'b11);
        tick();
        check_all("unm_okay");
        chk("unm_okay.resp_direct", {30'b0, HREADY, HRESP}, 32'b10);
        tick();

        // Two consecutive unmapped transfers
        drive(32'h3000_0000, 2'b10, 3'b111, 3'b000);
        tick();
        drive(32'h4000_0000, 2'b10, 3'b111, 3'b000);
        check_all("b2b_err1a");
        tick();
        check_all("b2b_err2a");
        tick();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        check_all("b2b_err1b");
        chk("b2b_err1b.resp_direct", {30'b0, HREADY, HRESP}, 32'b01);
        tick();
        check_all("b2b_err2b");
        chk("b2b_err2b.resp_direct", {30'b0, HREADY, HRESP}, 32'b11);
        tick();

        // Mapped transfer accepted in the second error cycle
        drive(32'h5000_0000, 2'b10, 3'b111, 3'b000);
        tick();
        check_all("map_err1");
        tick();
        drive(32'h0000_0040, 2'b10, 3'b111, 3'b000);
        check_all("map_err2");
        tick();
        drive(32'h0000_0000, 2'b00, 3'b110, 3'b001);
        check_all("map_follow");
        chk("map_follow.sel_direct", {30'b0, SEL}, 32'h1);
        rdy_v = 3'b111;
        tick();

        // Reset asserted during the first error cycle
        drive(32'h3000_0000, 2'b10, 3'b111, 3'b000);
        tick();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        check_all("rst_err1");
        RST = 1'b1;
        m_sel = 0;
        m_err = 0;
        #1;
        check_all("rst_mid");
        chk("rst_mid.resp_direct", {29'b0, SEL, HREADY, HRESP}, 32'b0010);
        tick();
        RST = 1'b0;
        drive(32'h2000_0000, 2'b10, 3'b111, 3'b000);
        check_all("rst_resume");
        tick();
        drive(32'h0000_0000, 2'b00, 3'b111, 3'b000);
        check_all("rst_resume_sel");
        tick();

        // Random traffic, including stalls, errors and unmapped regions
        for (int i = 0; i < 400; i++) begin
            rg = 4'($urandom_range(0, 5));
            ra = {rg, 28'($urandom)};
            drive(ra, 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111,
                  ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000);
            check_all("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
